elevator_plant_model: RTL and testbench

Parametrised behavioural plant model of an N-floor elevator car and its door, used as the closed-loop stimulus partner for the elevator controller in simulation. It turns the controller's engine and door commands into timed position, floor and door sensor feedback. It adds a per-floor position counter, door travel in both directions, obstruction reversal, interlocks and limit detection.

---
 rtl/elevator_plant_model.sv | 171 +++++++++++++++++
 tb/tb_elevator_plant_model.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/elevator_plant_model.sv
// rtl/elevator_plant_model.sv - behavioural N-floor elevator car and door plant model
// Turns engine/door commands into timed floor, door and fault feedback.
module elevator_plant_model #(
    parameter int FLOORS       = 8,
    parameter int FLOOR_W      = 3,
    parameter int DELAY_ENGINE = 10,
    parameter int DELAY_DOOR   = 10,
    parameter int START_FLOOR  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         engine,
    input  logic [1:0]         door,
    input  logic               obstruct,
    output logic [FLOOR_W-1:0] floor_pos,
    output logic [FLOORS-1:0]  sensor_floor,
    output logic               at_floor,
    output logic               arrive,
    output logic [1:0]         sensor_door,
    output logic               obstruct_evt,
    output logic               interlock_err,
    output logic               limit_err
);

    localparam int TC_W = $clog2(DELAY_ENGINE);
    localparam int DC_W = $clog2(DELAY_DOOR + 1);

    localparam logic [TC_W-1:0]    TC_ZERO   = '0;
    localparam logic [TC_W-1:0]    TC_ONE    = TC_W'(1);
    localparam logic [TC_W-1:0]    TC_MAX    = TC_W'(DELAY_ENGINE - 1);
    localparam logic [DC_W-1:0]    DC_ZERO   = '0;
    localparam logic [DC_W-1:0]    DC_ONE    = DC_W'(1);
    localparam logic [DC_W-1:0]    DC_MAX    = DC_W'(DELAY_DOOR);
    localparam logic [DC_W-1:0]    DC_NEAR   = DC_W'(DELAY_DOOR - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_RST = FLOOR_W'(START_FLOOR);

    typedef enum logic [1:0] {
        D_CLOSED,
        D_OPENING,
        D_OPEN,
        D_CLOSING
    } door_state_e;

    door_state_e        dstate_q, dstate_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [TC_W-1:0]    tc_q, tc_d;
    logic [DC_W-1:0]    dc_q, dc_d;
    logic               reopen_q, reopen_d;
    logic               arrive_q, arrive_d;
    logic               evt_q, evt_d;
    logic               interlock_q, interlock_d;
    logic               limit_q, limit_d;

    logic eng_up, eng_dn, eng_idle;
    logic level, door_closed, door_full, rev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dstate_q    <= D_CLOSED;
            floor_q     <= FLOOR_RST;
            tc_q        <= TC_ZERO;
            dc_q        <= DC_ZERO;
            reopen_q    <= 1'b0;
            arrive_q    <= 1'b0;
            evt_q       <= 1'b0;
            interlock_q <= 1'b0;
            limit_q     <= 1'b0;
        end else begin
            dstate_q    <= dstate_d;
            floor_q     <= floor_d;
            tc_q        <= tc_d;
            dc_q        <= dc_d;
            reopen_q    <= reopen_d;
            arrive_q    <= arrive_d;
            evt_q       <= evt_d;
            interlock_q <= interlock_d;
            limit_q     <= limit_d;
        end
    end

    always_comb begin
        floor_d     = floor_q;
        tc_d        = tc_q;
        dc_d        = dc_q;
        dstate_d    = dstate_q;
        reopen_d    = reopen_q;
        arrive_d    = 1'b0;
        evt_d       = 1'b0;
        interlock_d = 1'b0;
        limit_d     = 1'b0;

        eng_up      = (engine == 2'd2);
        eng_dn      = (engine == 2'd1);
        eng_idle    = !eng_up && !eng_dn;
        level       = (tc_q == TC_ZERO);
        door_closed = (dc_q == DC_ZERO);
        door_full   = (dc_q == DC_MAX);

        // Car motion always judges the door by its pre-edge counter.
        if (!eng_idle && !door_closed) begin
            interlock_d = 1'b1;
        end else if (eng_up) begin
            if (level && floor_q == FLOOR_TOP) begin
                limit_d = 1'b1;
            end else if (tc_q == TC_MAX) begin
                floor_d  = floor_q + FLOOR_ONE;
                tc_d     = TC_ZERO;
                arrive_d = 1'b1;
            end else begin
                tc_d = tc_q + TC_ONE;
            end
        end else if (eng_dn) begin
            if (!level) begin
                tc_d     = tc_q - TC_ONE;
                arrive_d = (tc_q == TC_ONE);
            end else if (floor_q == '0) begin
                limit_d = 1'b1;
            end else begin
                floor_d = floor_q - FLOOR_ONE;
                tc_d    = TC_MAX;
            end
        end

        // A reversal latches reopen_q so the door keeps opening until fully open,
        // whatever the door command does meanwhile; only one event per reversal.
        rev = obstruct && !reopen_q && !door_full && !door_closed &&
              (dstate_q == D_CLOSING || door == 2'd2);

        if (rev || reopen_q) begin
            evt_d    = rev;
            dc_d     = door_full ? dc_q : dc_q + DC_ONE;
            reopen_d = (dc_q != DC_NEAR) && !door_full;
            dstate_d = D_OPENING;
        end else if (door == 2'd1 && level && eng_idle) begin
            if (!door_full) begin
                dc_d = dc_q + DC_ONE;
            end
            dstate_d = D_OPENING;
        end else if (door == 2'd2) begin
            if (!door_closed && !(door_full && obstruct)) begin
                dc_d     = dc_q - DC_ONE;
                dstate_d = D_CLOSING;
            end
        end

        if (dc_d == DC_ZERO) begin
            dstate_d = D_CLOSED;
        end else if (dc_d == DC_MAX) begin
            dstate_d = D_OPEN;
        end
    end

    assign floor_pos     = floor_q;
    assign at_floor      = (tc_q == TC_ZERO);
    assign arrive        = arrive_q;
    assign obstruct_evt  = evt_q;
    assign interlock_err = interlock_q;
    assign limit_err     = limit_q;
    assign sensor_door   = (dc_q == DC_ZERO) ? 2'd2 :
                           (dc_q == DC_MAX)  ? 2'd1 : 2'd0;

    always_comb begin
        sensor_floor = '0;
        for (int i = 0; i < FLOORS; i++) begin
            sensor_floor[i] = at_floor && (floor_q == FLOOR_W'(i));
        end
    end

endmodule

// File: tb/tb_elevator_plant_model.sv
// tb/tb_elevator_plant_model.sv - table-driven self-checking bench for elevator_plant_model
module tb_elevator_plant_model;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] engine = 2'd0;
    logic [1:0] door = 2'd0;
    logic       obstruct = 1'b0;
    logic [2:0] floor_pos;
    logic [7:0] sensor_floor;
    logic       at_floor, arrive, obstruct_evt, interlock_err, limit_err;
    logic [1:0] sensor_door;

    int checks = 0;
    int errors = 0;

    elevator_plant_model #(
        .FLOORS(8), .FLOOR_W(3), .DELAY_ENGINE(10), .DELAY_DOOR(10), .START_FLOOR(0)
    ) dut (
        .clk(clk), .reset(reset), .engine(engine), .door(door), .obstruct(obstruct),
        .floor_pos(floor_pos), .sensor_floor(sensor_floor), .at_floor(at_floor),
        .arrive(arrive), .sensor_door(sensor_door), .obstruct_evt(obstruct_evt),
        .interlock_err(interlock_err), .limit_err(limit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] eng;
        logic [1:0] dr;
        logic       obs;
        logic [2:0] fp;
        logic       af;
        logic       arr;
        logic [1:0] sd;
        logic       il;
        logic       lim;
        logic       evt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n, input logic [1:0] e, input logic [1:0] d,
                                input logic o, input logic [2:0] fp, input logic af,
                                input logic arr, input logic [1:0] sd, input logic il,
                                input logic lim, input logic evt);
        vec_t v;
        v = '{eng: e, dr: d, obs: o, fp: fp, af: af, arr: arr, sd: sd, il: il, lim: lim, evt: evt};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int idx, input logic [2:0] fp, input logic af,
                           input logic arr, input logic [1:0] sd, input logic il,
                           input logic lim, input logic evt);
        logic [7:0] sf;
        sf = af ? (8'b1 << fp) : 8'b0;
        chk({nm, ".floor_pos"}, idx, 32'(floor_pos), 32'(fp));
        chk({nm, ".at_floor"}, idx, 32'(at_floor), 32'(af));
        chk({nm, ".sensor_floor"}, idx, 32'(sensor_floor), 32'(sf));
        chk({nm, ".arrive"}, idx, 32'(arrive), 32'(arr));
        chk({nm, ".sensor_door"}, idx, 32'(sensor_door), 32'(sd));
        chk({nm, ".interlock_err"}, idx, 32'(interlock_err), 32'(il));
        chk({nm, ".limit_err"}, idx, 32'(limit_err), 32'(lim));
        chk({nm, ".obstruct_evt"}, idx, 32'(obstruct_evt), 32'(evt));
    endtask

    task automatic step(input logic [1:0] e, input logic [1:0] d, input logic o);
        @(negedge clk);
        engine = e;
        door = d;
        obstruct = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // eng, door, obs | floor, at, arrive, sdoor, interlock, limit, evt
        add(9, 2, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 2, 0, 0, 1, 1, 1, 2, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
        add(9, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0);
        add(4, 2, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(3, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(3, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 0, 2, 0, 1, 0);
        add(9, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 2, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(4, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 2, 1, 0, 1, 0, 0, 0, 0, 1);
        add(2, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 2, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 2, 1, 0, 1, 0, 1, 0, 0, 0);
        add(9, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 2, 0, 0, 1, 0, 2, 0, 0, 0);
        add(1, 2, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0);

        #2;
        chk_all("reset_hold", 0, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("reset_rel", 0, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].eng, vecs[i].dr, vecs[i].obs);
            chk_all("vec", i, vecs[i].fp, vecs[i].af, vecs[i].arr, vecs[i].sd,
                    vecs[i].il, vecs[i].lim, vecs[i].evt);
        end

        // Climb to the top floor, then press against the limit.
        for (int i = 0; i < 70; i++) step(2'd2, 2'd0, 1'b0);
        chk_all("top", 0, 3'd7, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        step(2'd2, 2'd0, 1'b0);
        chk_all("top_limit", 0, 3'd7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(2'd1, 2'd0, 1'b0);
        chk_all("mid_travel", 0, 3'd6, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-travel, observed before any clock edge.
        #1 reset = 1'b0;
        #1;
        chk_all("async_rst", 0, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        engine = 2'd0;
        reset = 1'b1;

        for (int i = 0; i < 3; i++) step(2'd0, 2'd1, 1'b0);
        chk_all("door_part", 0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk_all("door_rst", 0, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        door = 2'd0;
        reset = 1'b1;
        step(2'd2, 2'd0, 1'b0);
        chk_all("post_rst", 0, 3'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
